// File: rtl/frame_update_scheduler_if.sv
// Bus bundle for frame_update_scheduler: blanking input, per-slot req/ack handshake,
// error clear and status outputs. master = scheduler side, slave = environment side.
interface frame_update_scheduler_if #(
    parameter int unsigned CNT_W = 16
);
    logic             vblnk_in;
    logic [2:0]       upd_ack;
    logic             clr_err;
    logic [2:0]       upd_req;
    logic             commit;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;
    logic [2:0]       timeout_err;
    logic             overrun;

    modport master (
        input  vblnk_in, upd_ack, clr_err,
        output upd_req, commit, busy, frame_cnt, timeout_err, overrun
    );

    modport slave (
        output vblnk_in, upd_ack, clr_err,
        input  upd_req, commit, busy, frame_cnt, timeout_err, overrun
    );
endinterface

// File: rtl/frame_update_scheduler.sv
// Per-frame update scheduler: grants mallet1, mallet2, puck slots during vblank, then pulses commit.
// Optional macro FRAME_SKIP_EN: run the sequence only on every FRAME_DIV-th frame.
module frame_update_scheduler #(
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned FRAME_DIV = 2
) (
    input  logic                      clk_in,
    input  logic                      rst,
    frame_update_scheduler_if.master  bus
);
    localparam int unsigned TO_W = $clog2(TIMEOUT);

    if (TIMEOUT < 2 || FRAME_DIV < 1) begin : g_param_check
        $error("frame_update_scheduler: TIMEOUT must be >= 2 and FRAME_DIV >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SLOT0,
        S_SLOT1,
        S_SLOT2,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_vblnk_d;
    logic             r_start;
    logic             r_end;
    logic [TO_W-1:0]  r_tcnt;
    logic [TO_W-1:0]  w_tcnt_nxt;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [2:0]       r_timeout_err;
    logic             r_overrun;
    logic [2:0]       r_upd_req;
    logic [2:0]       w_req_nxt;
    logic             r_commit;
    logic             r_busy;
    logic             w_start_edge;
    logic             w_end_edge;
    logic             w_ack_hit;
    logic             w_tout_hit;
    logic [2:0]       w_terr_set;
    logic             w_ovr_set;
    logic             w_run;

    // Edge detects are registered so the FSM sees start/end one cycle after the edge.
    assign w_start_edge = bus.vblnk_in & ~r_vblnk_d;
    assign w_end_edge   = ~bus.vblnk_in & r_vblnk_d;
    assign w_ack_hit    = |(bus.upd_ack & r_upd_req);
    assign w_tout_hit   = (r_tcnt == TO_W'(TIMEOUT - 1));

`ifdef FRAME_SKIP_EN
    localparam int unsigned PH_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    logic [PH_W-1:0] r_phase;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_phase <= '0;
        end else if (r_start) begin
            r_phase <= (r_phase == PH_W'(FRAME_DIV - 1)) ? '0 : r_phase + PH_W'(1);
        end
    end

    assign w_run = (r_phase == '0);
`else
    assign w_run = 1'b1;
`endif

    always_comb begin
        w_next     = r_state;
        w_terr_set = '0;
        w_ovr_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_start && w_run) w_next = S_SLOT0;
            end
            S_SLOT0, S_SLOT1, S_SLOT2: begin
                // Blanking end outranks a same-cycle ack or timeout.
                if (r_end) begin
                    w_next    = S_IDLE;
                    w_ovr_set = 1'b1;
                end else if (w_ack_hit || w_tout_hit) begin
                    if (!w_ack_hit) w_terr_set = r_upd_req;
                    case (r_state)
                        S_SLOT0: w_next = S_SLOT1;
                        S_SLOT1: w_next = S_SLOT2;
                        default: w_next = S_DONE;
                    endcase
                end
            end
            S_DONE: begin
                w_next = (r_start && w_run) ? S_SLOT0 : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_req_nxt = '0;
        case (w_next)
            S_SLOT0: w_req_nxt = 3'b001;
            S_SLOT1: w_req_nxt = 3'b010;
            S_SLOT2: w_req_nxt = 3'b100;
            default: w_req_nxt = '0;
        endcase
    end

    assign w_tcnt_nxt = (r_busy && (w_next == r_state)) ? r_tcnt + TO_W'(1) : '0;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_vblnk_d     <= 1'b0;
            r_start       <= 1'b0;
            r_end         <= 1'b0;
            r_tcnt        <= '0;
            r_frame_cnt   <= '0;
            r_timeout_err <= '0;
            r_overrun     <= 1'b0;
            r_upd_req     <= '0;
            r_commit      <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_vblnk_d     <= bus.vblnk_in;
            r_start       <= w_start_edge;
            r_end         <= w_end_edge;
            r_state       <= w_next;
            r_tcnt        <= w_tcnt_nxt;
            r_upd_req     <= w_req_nxt;
            r_commit      <= (w_next == S_DONE);
            r_busy        <= (w_req_nxt != '0);
            if (r_start) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            // A new error in the clearing cycle keeps its flag set.
            r_timeout_err <= (bus.clr_err ? 3'b000 : r_timeout_err) | w_terr_set;
            r_overrun     <= (bus.clr_err ? 1'b0 : r_overrun) | w_ovr_set;
        end
    end

    assign bus.upd_req     = r_upd_req;
    assign bus.commit      = r_commit;
    assign bus.busy        = r_busy;
    assign bus.frame_cnt   = r_frame_cnt;
    assign bus.timeout_err = r_timeout_err;
    assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Self-checking bench for frame_update_scheduler: frame-level timing model vs. DUT, cycle by cycle.
module tb_frame_update_scheduler;
    localparam int unsigned TIMEOUT   = 16;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned FRAME_DIV = 2;
    localparam int          NEVER     = 1000;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    int         m_cnt;
    int         m_frames;
    logic [2:0] m_terr;
    logic       m_ovr;

    frame_update_scheduler_if #(.CNT_W(CNT_W)) bus ();

    frame_update_scheduler #(
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (CNT_W),
        .FRAME_DIV(FRAME_DIV)
    ) dut (
        .clk_in(clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic bit frame_runs(input int k);
`ifdef FRAME_SKIP_EN
        return ((k - 1) % int'(FRAME_DIV)) == 0;
`else
        return k >= 1;
`endif
    endfunction

    task automatic apply_reset;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.vblnk_in = 1'b0;
        bus.upd_ack  = 3'b000;
        bus.clr_err  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_cnt = 0; m_frames = 0; m_terr = 3'b000; m_ovr = 1'b0;
    endtask

    // One blanking frame: vblnk high for L cycles, low for G. Slot i acks d_i cycles after
    // its slot opens (d_i >= TIMEOUT means never). Expected outputs follow from slot lengths.
    task automatic drive_and_check_frame(input string tag, input int d0, input int d1,
                                         input int d2, input int L, input int G,
                                         input int clr_at, input bit noise);
        int d[3];
        int st[4];
        int ln[3];
        bit to[3];
        int dsum;
        bit run, ab;
        logic [2:0] e_req, ev_t;
        logic e_commit, ev_o;
        d[0] = d0; d[1] = d1; d[2] = d2;
        m_frames++;
        run = frame_runs(m_frames);
        st[0] = 2;
        for (int i = 0; i < 3; i++) begin
            to[i] = d[i] >= int'(TIMEOUT);
            ln[i] = to[i] ? int'(TIMEOUT) : d[i] + 1;
            st[i+1] = st[i] + ln[i];
        end
        dsum = st[3] - 2;
        ab = run && (L <= dsum);
        for (int c = 0; c < L + G; c++) begin
            @(posedge clk); #1;
            bus.vblnk_in = (c < L);
            bus.clr_err  = (c == clr_at);
            for (int j = 0; j < 3; j++) begin
                if (c < st[j]) bus.upd_ack[j] = noise ? 1'($urandom) : 1'b0;
                else           bus.upd_ack[j] = !to[j] && (c >= st[j] + d[j]);
            end
            @(negedge clk);
            if (c == 2) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            e_req = 3'b000;
            if (run && !(ab && c > L + 1))
                for (int i = 0; i < 3; i++)
                    if (c >= st[i] && c < st[i] + ln[i]) e_req[i] = 1'b1;
            e_commit = run && !ab && (c == st[3]);

            n_tests++;
            if (bus.upd_req !== e_req) begin
                n_fail++;
                $display("FAIL %s upd_req c=%0d: got %b want %b", tag, c, bus.upd_req, e_req);
            end
            n_tests++;
            if (bus.commit !== e_commit) begin
                n_fail++;
                $display("FAIL %s commit c=%0d: got %b want %b", tag, c, bus.commit, e_commit);
            end
            n_tests++;
            if (bus.busy !== (e_req != 3'b000)) begin
                n_fail++;
                $display("FAIL %s busy c=%0d: got %b want %b", tag, c, bus.busy, e_req != 3'b000);
            end
            n_tests++;
            if (bus.frame_cnt !== CNT_W'(m_cnt)) begin
                n_fail++;
                $display("FAIL %s frame_cnt c=%0d: got %0d want %0d", tag, c, bus.frame_cnt, m_cnt);
            end
            n_tests++;
            if (bus.timeout_err !== m_terr) begin
                n_fail++;
                $display("FAIL %s timeout_err c=%0d: got %b want %b", tag, c, bus.timeout_err, m_terr);
            end
            n_tests++;
            if (bus.overrun !== m_ovr) begin
                n_fail++;
                $display("FAIL %s overrun c=%0d: got %b want %b", tag, c, bus.overrun, m_ovr);
            end

            ev_t = 3'b000;
            for (int i = 0; i < 3; i++)
                if (run && to[i] && c == st[i] + ln[i] - 1 && !(ab && c >= L + 1)) ev_t[i] = 1'b1;
            ev_o = ab && (c == L + 1);
            if (c == clr_at) begin
                m_terr = ev_t; m_ovr = ev_o;
            end else begin
                m_terr = m_terr | ev_t; m_ovr = m_ovr | ev_o;
            end
        end
        bus.clr_err = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.vblnk_in = 1'b0; bus.upd_ack = 3'b000; bus.clr_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({bus.upd_req, bus.commit, bus.busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset req/commit/busy: got %b want 00000", {bus.upd_req, bus.commit, bus.busy});
        end
        n_tests++;
        if (bus.frame_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset frame_cnt: got %0d want 0", bus.frame_cnt);
        end
        n_tests++;
        if ({bus.timeout_err, bus.overrun} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset flags: got %b want 0000", {bus.timeout_err, bus.overrun});
        end
        apply_reset();
    endtask

    task automatic test_best_case;
        apply_reset();
        drive_and_check_frame("best_case", 0, 0, 0, 10, 4, -1, 1'b0);
    endtask

    task automatic test_late_ack;
        apply_reset();
        drive_and_check_frame("late_ack", 0, 5, 0, 20, 3, -1, 1'b1);
    endtask

    task automatic test_timeout;
        apply_reset();
        drive_and_check_frame("timeout", NEVER, 0, 0, 30, 3, -1, 1'b0);
        drive_and_check_frame("timeout_edge", int'(TIMEOUT) - 1, 2, NEVER, 45, 3, -1, 1'b0);
    endtask

    task automatic test_overrun;
        apply_reset();
        drive_and_check_frame("overrun", 0, NEVER, 0, 5, 8, 9, 1'b0);
        drive_and_check_frame("final_ack_end", 0, 0, 0, 3, 4, -1, 1'b0);
    endtask

    task automatic test_clr_collision;
        apply_reset();
        drive_and_check_frame("clr_collide", NEVER, 0, 0, 40, 3, 2 + int'(TIMEOUT) - 1, 1'b0);
    endtask

    task automatic test_reset_mid;
        apply_reset();
        m_frames++;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            bus.vblnk_in = (c < 5);
            bus.upd_ack  = (c >= 2) ? 3'b001 : 3'b000;
            rst          = (c == 4);
            @(negedge clk);
            if (c == 4) begin
                n_tests++;
                if (bus.upd_req !== 3'b010) begin
                    n_fail++;
                    $display("FAIL reset_mid pre req: got %b want 010", bus.upd_req);
                end
            end
            if (c == 5) begin
                n_tests++;
                if ({bus.upd_req, bus.commit, bus.busy, bus.timeout_err, bus.overrun} !== 9'b0 ||
                    bus.frame_cnt !== '0) begin
                    n_fail++;
                    $display("FAIL reset_mid outputs: got req=%b commit=%b busy=%b cnt=%0d terr=%b ovr=%b want all 0",
                             bus.upd_req, bus.commit, bus.busy, bus.frame_cnt, bus.timeout_err, bus.overrun);
                end
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.upd_ack = 3'b000;
        m_cnt = 0; m_frames = 0; m_terr = 3'b000; m_ovr = 1'b0;
        repeat (2) @(posedge clk);
        drive_and_check_frame("restart", 0, 0, 0, 8, 3, -1, 1'b0);
    endtask

    task automatic test_wrap;
        apply_reset();
        for (int k = 0; k < 17; k++)
            drive_and_check_frame($sformatf("wrap%0d", k), 0, 0, 0, 6, 3, -1, 1'b0);
        n_tests++;
        if (bus.frame_cnt !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL wrap frame_cnt after 17 frames: got %0d want 1", bus.frame_cnt);
        end
    endtask

    task automatic test_random;
        int d[3];
        int r, ds, L, G, ca;
        apply_reset();
        for (int k = 0; k < 25; k++) begin
            ds = 0;
            for (int j = 0; j < 3; j++) begin
                r = int'($urandom_range(0, 7));
                d[j] = (r < 6) ? r : ((r == 6) ? int'(TIMEOUT) - 1 : NEVER);
                ds += (d[j] >= int'(TIMEOUT)) ? int'(TIMEOUT) : d[j] + 1;
            end
            if ($urandom_range(0, 1) == 1) L = ds + int'($urandom_range(0, 4)) - 2;
            else                           L = int'($urandom_range(1, 60));
            if (L < 1) L = 1;
            G  = int'($urandom_range(2, 6));
            ca = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, L + G - 2)) : -1;
            drive_and_check_frame($sformatf("rand%0d", k), d[0], d[1], d[2], L, G, ca, 1'b1);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.vblnk_in = 1'b0;
        bus.upd_ack  = 3'b000;
        bus.clr_err  = 1'b0;
        test_reset();
        test_best_case();
        test_late_ack();
        test_timeout();
        test_overrun();
        test_clr_collision();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got still running want finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
